evaluar_pareja: RTL
===================

# evaluar_pareja

Resolves a round of the memory game once two cards have been turned face-up. It reads the 16-entry card array after the selection stage has marked cards, and finds the two cards in state "selected". It holds them visible for a fixed display time, then writes them back as "matched" if their identifiers are equal or as "hidden" if they differ. It sits after the pair-selection stage in the game controller loop, and also keeps the running count of matched pairs and flags game completion.

## Interface
- SHOW_CYCLES, 50_000_000: display hold time in clock cycles, ≥1 (1 s at 50 MHz). The counter width is $clog2(SHOW_CYCLES+1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to evaluate `arr_in`; ignored unless in IDLE.
- arr_in  in  5×16 (unpacked [0:15])  card array. Bits [4:2] are the card id (0–7); bits [1:0] are the state: 00 hidden, 01 selected, 10 matched, 11 unused.
- arr_out  out  5×16 (unpacked [0:15])  resolved card array; holds its value between rounds.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when `arr_out` is updated for this round.
- match  out  1  valid while `done` is high: 1 means the pair matched.
- error  out  1  valid while `done` is high: 1 means the selected count was not exactly 2.
- parejas  out  4  matched-pair counter, 0..8, saturating.
- game_over  out  1  high while `parejas` == 8.

## Operation
- States: IDLE, SCAN, SHOW, RESOLVE.
- **IDLE**
  - On `start`: latch `arr_in` into the internal copy `arr_q`, clear the scan index, selected count and both stored indices, then go to SCAN.
- **SCAN** (16 cycles, index 0..15, one entry per cycle)
  - If `arr_q[idx][1:0]` == 01: store `idx` as `idx_a` when the count is 0, or as `idx_b` when the count is 1.
  - The count increments and saturates at 3.
  - After index 15: go to SHOW if the count == 2, otherwise go to RESOLVE with the error flag set.
- **SHOW**
  - Count SHOW_CYCLES cycles, then go to RESOLVE.
  - `arr_out` is not changed during SHOW.
- **RESOLVE** (1 cycle, then IDLE)
  - Error case: `arr_out` ← `arr_q` unchanged; `match` = 0, `error` = 1.
  - Otherwise, if `arr_q[idx_a][4:2]` == `arr_q[idx_b][4:2]`:
    - both entries' [1:0] ← 10; `match` = 1;
    - `parejas` increments unless it is already 8.
  - Otherwise, both entries' [1:0] ← 00; `match` = 0.
  - In every case, all other entries are copied from `arr_q` and `done` = 1.
- Card ids are never modified. Only bits [1:0] of `idx_a`/`idx_b` change.
- `start` asserted while `busy` is high is dropped; it is not queued.
- Entries in state 10 or 11 are skipped by SCAN.

## Timing
- Reset (asynchronous, any state):
  - state → IDLE; `arr_out`, `arr_q` all 0;
  - `busy`, `done`, `match`, `error` = 0; `parejas` = 0.
  - Reset mid-round abandons the round with no `done` pulse.
- Start at edge E0 enters SCAN; `busy` is high from the cycle after E0.
- Edges E1..E16 scan indices 0..15.
- Valid pair:
  - SHOW occupies edges E17..E(16+SHOW_CYCLES).
  - The RESOLVE edge E(17+SHOW_CYCLES) updates `arr_out`, `match` and `parejas`, and pulses `done`.
  - `busy` falls together with `done`.
- Error case: `done` and `error` assert at E17, skipping SHOW.
- Total latency from start to `done` is 17+SHOW_CYCLES edges (valid pair) or 17 edges (error).
- `done`, `match` and `error` are registered, high for exactly one cycle, and 0 otherwise.
- A new `start` is accepted in the cycle after `done`.

## Test plan
1. SHOW_CYCLES=4; `arr_in` has id 3 at indices 2 and 9, both state 01, all others hidden.
   - Pulse start → `done` at edge 21 with `match`=1.
   - `arr_out[2]` = `arr_out[9]` = 5'b01110; `parejas` = 1; all other entries unchanged.
2. id 1 at index 0 and id 6 at index 15, both selected.
   - → `done` with `match`=0; `arr_out[0]` = 5'b00100, `arr_out[15]` = 5'b11000.
   - `parejas` unchanged.
3. Only one entry in state 01.
   - → `done` and `error` at edge 17; `arr_out` == `arr_in`.
   - Repeat with three selected entries → same error result.
4. Start pulsed again during SHOW → ignored: only one `done` pulse.
   - Assert `rst` during SHOW → no `done`; all outputs 0.
   - A fresh start after reset completes normally.
5. Eight consecutive matching rounds → `parejas` reaches 8 and `game_over` = 1.
   - A ninth matching round keeps `parejas` = 8.
6. Matched entries (state 10) plus two selected entries with equal ids → SCAN ignores the 10 entries.
   - The result is `match`=1 on exactly the two selected indices.

Source files
------------

// File: rtl/evaluar_pareja_if.sv
// rtl/evaluar_pareja_if.sv - request/response bundle between the game loop and the pair evaluator
interface evaluar_pareja_if;
    logic       start;
    logic [4:0] arr_in  [0:15];
    logic [4:0] arr_out [0:15];
    logic       busy;
    logic       done;
    logic       match;
    logic       error;
    logic [3:0] parejas;
    logic       game_over;

    modport master (
        output start, arr_in,
        input  arr_out, busy, done, match, error, parejas, game_over
    );

    modport slave (
        input  start, arr_in,
        output arr_out, busy, done, match, error, parejas, game_over
    );
endinterface

// File: rtl/evaluar_pareja.sv
// rtl/evaluar_pareja.sv - finds the two selected cards, shows them, then marks matched or hides them
module evaluar_pareja #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    evaluar_pareja_if.slave  bus
);
    localparam int CW = $clog2(SHOW_CYCLES + 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHOW, RESOLVE} state_t;

    state_t        state, state_nx;
    logic [4:0]    arr_q [0:15];
    logic [3:0]    idx, idx_a, idx_b;
    logic [1:0]    cnt, cnt_nx;
    logic [CW-1:0] show_cnt;
    logic          sel_hit, pair_ok, same_id;

    assign sel_hit = (arr_q[idx][1:0] == 2'b01);
    assign cnt_nx  = (sel_hit && cnt != 2'd3) ? cnt + 2'd1 : cnt;
    assign pair_ok = (cnt == 2'd2);
    assign same_id = (arr_q[idx_a][4:2] == arr_q[idx_b][4:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SCAN;
            // the last entry's hit is folded in through cnt_nx
            SCAN:    if (idx == 4'd15) state_nx = (cnt_nx == 2'd2) ? SHOW : RESOLVE;
            SHOW:    if (show_cnt == SHOW_LAST) state_nx = RESOLVE;
            RESOLVE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.game_over = (bus.parejas == 4'd8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                arr_q[i]       <= '0;
                bus.arr_out[i] <= '0;
            end
            idx         <= '0;
            idx_a       <= '0;
            idx_b       <= '0;
            cnt         <= '0;
            show_cnt    <= '0;
            bus.done    <= 1'b0;
            bus.match   <= 1'b0;
            bus.error   <= 1'b0;
            bus.parejas <= '0;
        end else begin
            bus.done  <= 1'b0;
            bus.match <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 16; i++) arr_q[i] <= bus.arr_in[i];
                        idx   <= '0;
                        idx_a <= '0;
                        idx_b <= '0;
                        cnt   <= '0;
                    end
                end
                SCAN: begin
                    if (sel_hit) begin
                        if (cnt == 2'd0)      idx_a <= idx;
                        else if (cnt == 2'd1) idx_b <= idx;
                    end
                    cnt      <= cnt_nx;
                    idx      <= idx + 4'd1;
                    show_cnt <= '0;
                end
                SHOW: show_cnt <= show_cnt + CW'(1);
                RESOLVE: begin
                    bus.done <= 1'b1;
                    for (int i = 0; i < 16; i++) bus.arr_out[i] <= arr_q[i];
                    // later per-entry writes override the bulk copy above
                    if (!pair_ok) begin
                        bus.error <= 1'b1;
                    end else if (same_id) begin
                        bus.match <= 1'b1;
                        bus.arr_out[idx_a][1:0] <= 2'b10;
                        bus.arr_out[idx_b][1:0] <= 2'b10;
                        if (bus.parejas != 4'd8) bus.parejas <= bus.parejas + 4'd1;
                    end else begin
                        bus.arr_out[idx_a][1:0] <= 2'b00;
                        bus.arr_out[idx_b][1:0] <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
